// File: rtl/rgb_pwm_sequencer_if.sv
// Table write port of the RGB PWM sequencer: one entry {hold, red, green, blue} per strobe.
interface rgb_pwm_sequencer_if #(
  parameter int unsigned IDX_W  = 2,
  parameter int unsigned DATA_W = 40
);
  logic              cfg_we;
  logic [IDX_W-1:0]  cfg_addr;
  logic [DATA_W-1:0] cfg_data;

  modport master (output cfg_we, cfg_addr, cfg_data);
  modport slave  (input  cfg_we, cfg_addr, cfg_data);
endinterface

// File: rtl/rgb_pwm_sequencer.sv
// Powers up the RGB driver current reference, then plays a table of colour steps
// as 8-bit PWM on the three channels, one step per programmable number of periods.
module rgb_pwm_sequencer #(
  parameter int unsigned PWM_W     = 8,
  parameter int unsigned N_STEPS   = 4,
  parameter int unsigned HOLD_W    = 16,
  parameter int unsigned PWRUP_CYC = 1200,
  localparam int unsigned IDX_W    = $clog2(N_STEPS),
  localparam int unsigned DATA_W   = HOLD_W + 3*PWM_W
) (
  input  logic              hw_clk,
  input  logic              rst_n,
  rgb_pwm_sequencer_if.slave cfg,
  input  logic              run,
  input  logic              loop,
  output logic              pwm_green,
  output logic              pwm_blue,
  output logic              pwm_red,
  output logic              curr_en,
  output logic              led_en,
  output logic              busy,
  output logic [IDX_W-1:0]  step_idx,
  output logic              done
);
  typedef enum logic [1:0] {IDLE, PWRUP, PLAY, DONE} state_t;

  localparam int unsigned      PWR_W    = $clog2(PWRUP_CYC + 1);
  localparam logic [PWM_W-1:0] PWM_LAST = PWM_W'((2**PWM_W) - 2);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] tbl [N_STEPS];
  logic [PWR_W-1:0]  pwr_cnt;
  logic [PWM_W-1:0]  pwm_cnt, duty_r, duty_g, duty_b;
  logic [HOLD_W-1:0] hold_cnt, act_hold, hold_last;
  logic [IDX_W-1:0]  next_idx;
  logic              wrap, step_end, last_step, pwr_done, play_entry, play_stay;

  always_comb begin
    wrap      = (pwm_cnt == PWM_LAST);
    // A hold of 0 behaves as 1: the step ends on its first period wrap.
    hold_last = (act_hold == '0) ? '0 : act_hold - 1'b1;
    step_end  = (state_q == PLAY) && wrap && (hold_cnt == hold_last);
    last_step = (step_idx == IDX_W'(N_STEPS - 1));
    pwr_done  = (pwr_cnt == PWR_W'(PWRUP_CYC - 1));
    next_idx  = step_idx + 1'b1;
    state_d   = state_q;
    case (state_q)
      IDLE:    if (run) state_d = PWRUP;
      PWRUP:   if (!run) state_d = IDLE;
               else if (pwr_done) state_d = PLAY;
      PLAY:    if (!run) state_d = IDLE;
               else if (step_end && last_step && !loop) state_d = DONE;
      DONE:    if (!run) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    play_entry = (state_q != PLAY) && (state_d == PLAY);
    play_stay  = (state_q == PLAY) && (state_d == PLAY);
  end

  always_ff @(posedge hw_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < N_STEPS; i++) tbl[i] <= '0;
    end else if (cfg.cfg_we) begin
      tbl[cfg.cfg_addr] <= cfg.cfg_data;
    end
  end

  always_ff @(posedge hw_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pwr_cnt   <= '0;
      pwm_cnt   <= '0;
      hold_cnt  <= '0;
      step_idx  <= '0;
      act_hold  <= '0;
      duty_r    <= '0;
      duty_g    <= '0;
      duty_b    <= '0;
      pwm_red   <= 1'b0;
      pwm_green <= 1'b0;
      pwm_blue  <= 1'b0;
      curr_en   <= 1'b0;
      led_en    <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q <= state_d;
      pwr_cnt <= (state_q == PWRUP) ? pwr_cnt + 1'b1 : '0;
      // Active regs are loaded only at step boundaries, so table writes never disturb a playing period.
      if (play_entry) begin
        step_idx <= '0;
        pwm_cnt  <= '0;
        hold_cnt <= '0;
        {act_hold, duty_r, duty_g, duty_b} <= tbl[0];
      end else if (play_stay) begin
        pwm_cnt <= wrap ? '0 : pwm_cnt + 1'b1;
        if (step_end) begin
          step_idx <= next_idx;
          hold_cnt <= '0;
          {act_hold, duty_r, duty_g, duty_b} <= tbl[next_idx];
        end else if (wrap) begin
          hold_cnt <= hold_cnt + 1'b1;
        end
      end else begin
        pwm_cnt <= '0;
      end
      pwm_red   <= (state_q == PLAY) && (pwm_cnt < duty_r);
      pwm_green <= (state_q == PLAY) && (pwm_cnt < duty_g);
      pwm_blue  <= (state_q == PLAY) && (pwm_cnt < duty_b);
      curr_en   <= (state_q == PWRUP) || (state_q == PLAY);
      led_en    <= (state_q == PLAY);
      done      <= (state_q == PLAY) && (state_d == DONE);
    end
  end

  assign busy = (state_q == PWRUP) || (state_q == PLAY);
endmodule

// File: tb/tb_rgb_pwm_sequencer.sv
// Scoreboard bench: expected per-period high counts and done events are queued at stimulus
// time; a monitor measures each PWM period while led_en is high and compares.
module tb_rgb_pwm_sequencer;
  localparam int unsigned PWM_W = 8, N_STEPS = 4, HOLD_W = 16, PWRUP_CYC = 8;
  localparam int unsigned IDX_W = 2, DATA_W = 40, PERIOD = 255;

  logic hw_clk = 1'b0, rst_n = 1'b0, run = 1'b1, loop = 1'b0;
  logic pwm_green, pwm_blue, pwm_red, curr_en, led_en, busy, done;
  logic [IDX_W-1:0] step_idx;

  rgb_pwm_sequencer_if #(.IDX_W(IDX_W), .DATA_W(DATA_W)) cfg_if ();

  rgb_pwm_sequencer #(.PWM_W(PWM_W), .N_STEPS(N_STEPS), .HOLD_W(HOLD_W), .PWRUP_CYC(PWRUP_CYC)) dut (
    .hw_clk(hw_clk), .rst_n(rst_n), .cfg(cfg_if), .run(run), .loop(loop),
    .pwm_green(pwm_green), .pwm_blue(pwm_blue), .pwm_red(pwm_red),
    .curr_en(curr_en), .led_en(led_en), .busy(busy), .step_idx(step_idx), .done(done)
  );

  always #5 hw_clk = ~hw_clk;

  typedef struct { int kind; int idx; int r; int g; int b; } exp_t;  // kind 0 = period, 1 = done
  exp_t exp_q[$];
  int n_cmp = 0, n_bad = 0;
  int m_hold[N_STEPS], m_r[N_STEPS], m_g[N_STEPS], m_b[N_STEPS];

  task automatic chk(string nm, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int eff(int h);
    return (h == 0) ? 1 : h;
  endfunction

  function automatic int push_entry(int idx, int h, int r, int g, int b);
    exp_t e;
    e.kind = 0; e.idx = idx; e.r = r; e.g = g; e.b = b;
    for (int k = 0; k < eff(h); k++) exp_q.push_back(e);
    return eff(h);
  endfunction

  function automatic void push_done();
    exp_t e;
    e.kind = 1; e.idx = 0; e.r = 0; e.g = 0; e.b = 0;
    exp_q.push_back(e);
  endfunction

  // ---------------- monitor ----------------
  int win_n = 0, win_idx = 0, cnt_r = 0, cnt_g = 0, cnt_b = 0, pu_cnt = 0;
  logic led_prev = 1'b0;
  exp_t me;

  always @(negedge hw_clk) begin
    if (!rst_n) begin
      win_n = 0; cnt_r = 0; cnt_g = 0; cnt_b = 0; pu_cnt = 0; led_prev = 1'b0;
    end else begin
      if (led_en) begin
        if (!led_prev) chk("pwrup_len", pu_cnt, PWRUP_CYC);
        if (win_n == 0) win_idx = int'(step_idx);
        cnt_r += int'(pwm_red); cnt_g += int'(pwm_green); cnt_b += int'(pwm_blue);
        win_n++;
        if (win_n == PERIOD) begin
          if (exp_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL period_unexpected: got step %0d r=%0d expected none", win_idx, cnt_r);
          end else begin
            me = exp_q.pop_front();
            chk("event_kind_period", 0, me.kind);
            chk("step_idx", win_idx, me.idx);
            chk("red_high", cnt_r, me.r);
            chk("green_high", cnt_g, me.g);
            chk("blue_high", cnt_b, me.b);
          end
          win_n = 0; cnt_r = 0; cnt_g = 0; cnt_b = 0;
        end
      end else begin
        chk("pwm_off_outside_play", int'({pwm_red, pwm_green, pwm_blue}), 0);
        win_n = 0; cnt_r = 0; cnt_g = 0; cnt_b = 0;
        pu_cnt = curr_en ? pu_cnt + 1 : 0;
      end
      if (done) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL done_unexpected: got done=1 expected 0");
        end else begin
          me = exp_q.pop_front();
          chk("event_kind_done", 1, me.kind);
        end
      end
      led_prev = led_en;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(int n);
    repeat (n) @(negedge hw_clk);
  endtask

  task automatic wr(int a, int h, int r, int g, int b);
    logic [15:0] hv; logic [7:0] rv, gv, bv;
    hv = h[15:0]; rv = r[7:0]; gv = g[7:0]; bv = b[7:0];
    cfg_if.cfg_we = 1'b1; cfg_if.cfg_addr = a[IDX_W-1:0]; cfg_if.cfg_data = {hv, rv, gv, bv};
    m_hold[a] = h; m_r[a] = r; m_g[a] = g; m_b[a] = b;
    @(negedge hw_clk);
    cfg_if.cfg_we = 1'b0;
  endtask

  function automatic int rnd_duty();
    int k;
    k = $urandom_range(0, 5);
    if (k == 0) return 0;
    if (k == 1) return 255;
    return $urandom_range(1, 254);
  endfunction

  task automatic rnd_table();
    for (int i = 0; i < N_STEPS; i++) wr(i, $urandom_range(0, 2), rnd_duty(), rnd_duty(), rnd_duty());
  endtask

  task automatic check_quiet(string nm);
    chk({nm, "_busy"}, int'(busy), 0);
    chk({nm, "_curr_en"}, int'(curr_en), 0);
    chk({nm, "_led_en"}, int'(led_en), 0);
    chk({nm, "_pwm"}, int'({pwm_red, pwm_green, pwm_blue}), 0);
    chk({nm, "_done"}, int'(done), 0);
  endtask

  task automatic start();
    run = 1'b1;
    @(negedge hw_clk);
    chk("busy_after_run", int'(busy), 1);
    chk("curr_en_lag", int'(curr_en), 0);
    @(negedge hw_clk);
    chk("curr_en_on", int'(curr_en), 1);
  endtask

  task automatic wait_led();
    int k = 0;
    while (!led_en && k < 100) begin @(negedge hw_clk); k++; end
    chk("led_en_rise_in_time", int'(led_en), 1);
  endtask

  task automatic play_once();
    int tot = 0;
    loop = 1'b0;
    for (int s = 0; s < N_STEPS; s++) tot += push_entry(s, m_hold[s], m_r[s], m_g[s], m_b[s]);
    push_done();
    start();
    wait_led();
    tick(tot * PERIOD);
    check_quiet("after_done");
    chk("queue_drained_done", exp_q.size(), 0);
    tick(300);
    chk("no_restart_busy", int'(busy), 0);
    run = 1'b0;
    tick(2);
  endtask

  task automatic live_loop();
    int n_full = 0, t = 0;
    int h0, r0, g0, b0, h2, r2, g2, b2;
    rnd_table();
    loop = 1'b1;
    h0 = $urandom_range(0, 2); r0 = rnd_duty(); g0 = rnd_duty(); b0 = rnd_duty();
    h2 = $urandom_range(0, 2); r2 = rnd_duty(); g2 = rnd_duty(); b2 = rnd_duty();
    n_full += push_entry(0, m_hold[0], m_r[0], m_g[0], m_b[0]);
    n_full += push_entry(1, m_hold[1], m_r[1], m_g[1], m_b[1]);
    n_full += push_entry(2, h2, r2, g2, b2);
    n_full += push_entry(3, m_hold[3], m_r[3], m_g[3], m_b[3]);
    n_full += push_entry(0, h0, r0, g0, b0);
    n_full += push_entry(1, m_hold[1], m_r[1], m_g[1], m_b[1]);
    n_full += push_entry(2, h2, r2, g2, b2);
    n_full += push_entry(3, m_hold[3], m_r[3], m_g[3], m_b[3]);
    n_full += push_entry(0, h0, r0, g0, b0);
    start();
    wait_led();
    tick(10); t = 10;
    wr(0, h0, r0, g0, b0); wr(2, h2, r2, g2, b2); t += 2;
    tick(n_full * PERIOD + 100 - t);
    chk("stop_in_step1", int'(step_idx), 1);
    run = 1'b0;
    @(negedge hw_clk);
    chk("stop_busy", int'(busy), 0);
    @(negedge hw_clk);
    check_quiet("after_stop");
    chk("queue_drained_stop", exp_q.size(), 0);
    tick(3);
  endtask

  initial begin
    cfg_if.cfg_we = 1'b0; cfg_if.cfg_addr = '0; cfg_if.cfg_data = '0;
    for (int i = 0; i < N_STEPS; i++) begin m_hold[i] = 0; m_r[i] = 0; m_g[i] = 0; m_b[i] = 0; end
    tick(3);
    check_quiet("reset_run1");
    chk("reset_step_idx", int'(step_idx), 0);
    run = 1'b0;
    rst_n = 1'b1;
    tick(5);
    check_quiet("idle_after_release");

    wr(0, 2, 8'h80, 8'h00, 8'hFF);
    for (int i = 1; i < N_STEPS; i++) wr(i, 1, 0, 0, 0);
    play_once();
    play_once();

    for (int it = 0; it < 3; it++) begin
      rnd_table();
      play_once();
    end

    for (int it = 0; it < 2; it++) live_loop();

    rnd_table();
    loop = 1'b1;
    void'(push_entry(0, 1, m_r[0], m_g[0], m_b[0]));
    start();
    wait_led();
    tick(300);
    rst_n = 1'b0;
    #1;
    check_quiet("async_reset");
    chk("async_reset_step_idx", int'(step_idx), 0);
    chk("queue_drained_reset", exp_q.size(), 0);
    for (int i = 0; i < N_STEPS; i++) begin m_hold[i] = 0; m_r[i] = 0; m_g[i] = 0; m_b[i] = 0; end
    run = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(2);
    play_once();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end
endmodule
